// File: rtl/lcd_sequencer.sv
// lcd_sequencer: timing controller for an HD44780-compatible character LCD.
//
// Runs the power-up wait, optionally issues the 8-bit init ROM, then turns
// each accepted command/data byte into a setup / E-pulse / hold / execution
// wait transfer. All phase lengths are in clk cycles; a length of 0 is
// treated as 1.
//
// Optional feature macro: LCD_INIT_SEQ_EN
//   defined   - after power-up the ROM 0x38,0x38,0x0C,0x01,0x06 is issued
//               before init_done/req_ready rise.
//   undefined - init_done/req_ready rise straight after power-up.
//
// Ports:
//   clk, reset_n           clock, asynchronous active-low reset
//   req_valid/req_ready    upstream byte handshake (ready only in IDLE)
//   req_rs, req_data       0 = command / 1 = data, byte to write
//   busy                   inverse of req_ready
//   init_done              sticky, power-up (and init) complete
//   LCD_E, LCD_RS, LCD_RW, LCD_data   registered panel pins (RW tied 0)

module lcd_sequencer #(
    parameter int CNT_W        = 20,
    parameter int T_POWERUP    = 750000,
    parameter int T_SETUP      = 3,
    parameter int T_PULSE      = 12,
    parameter int T_HOLD       = 2,
    parameter int T_CMD_WAIT   = 2000,
    parameter int T_CLEAR_WAIT = 82000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_rs,
    input  logic [7:0] req_data,
    output logic       busy,
    output logic       init_done,
    output logic       LCD_E,
    output logic       LCD_RS,
    output logic       LCD_RW,
    output logic [7:0] LCD_data
);

    typedef enum logic [2:0] {
        S_POWERUP,
`ifdef LCD_INIT_SEQ_EN
        S_INIT_LOAD,
`endif
        S_IDLE,
        S_SETUP,
        S_PULSE,
        S_HOLD,
        S_EXEC_WAIT
    } state_t;

    // Zero-length phases are clamped to one cycle.
    localparam logic [CNT_W-1:0] LEN_POWERUP = (T_POWERUP    > 0) ? CNT_W'(T_POWERUP)    : CNT_W'(1);
    localparam logic [CNT_W-1:0] LEN_SETUP   = (T_SETUP      > 0) ? CNT_W'(T_SETUP)      : CNT_W'(1);
    localparam logic [CNT_W-1:0] LEN_PULSE   = (T_PULSE      > 0) ? CNT_W'(T_PULSE)      : CNT_W'(1);
    localparam logic [CNT_W-1:0] LEN_HOLD    = (T_HOLD       > 0) ? CNT_W'(T_HOLD)       : CNT_W'(1);
    localparam logic [CNT_W-1:0] LEN_CMD     = (T_CMD_WAIT   > 0) ? CNT_W'(T_CMD_WAIT)   : CNT_W'(1);
    localparam logic [CNT_W-1:0] LEN_CLEAR   = (T_CLEAR_WAIT > 0) ? CNT_W'(T_CLEAR_WAIT) : CNT_W'(1);

    state_t           state_q,     state_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;
    logic             lcd_e_q,     lcd_e_d;
    logic             lcd_rs_q,    lcd_rs_d;
    logic [7:0]       lcd_data_q,  lcd_data_d;
    logic             init_done_q, init_done_d;
    logic [CNT_W-1:0] phase_len;
    logic             phase_last;
    logic             long_wait;

`ifdef LCD_INIT_SEQ_EN
    localparam logic [2:0] ROM_LEN = 3'd5;
    logic [2:0] rom_idx_q, rom_idx_d;

    function automatic logic [7:0] init_rom(input logic [2:0] idx);
        case (idx)
            3'd0:    init_rom = 8'h38;
            3'd1:    init_rom = 8'h38;
            3'd2:    init_rom = 8'h0C;
            3'd3:    init_rom = 8'h01;
            default: init_rom = 8'h06;
        endcase
    endfunction
`endif

    // Clear (0x01) and home (0x02/0x03) need the long execution wait.
    assign long_wait = !lcd_rs_q && (lcd_data_q[7:2] == 6'd0);

    // NOTE: every always_comb output gets a default before the case so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        phase_len = CNT_W'(1);
        case (state_q)
            S_POWERUP:   phase_len = LEN_POWERUP;
            S_SETUP:     phase_len = LEN_SETUP;
            S_PULSE:     phase_len = LEN_PULSE;
            S_HOLD:      phase_len = LEN_HOLD;
            S_EXEC_WAIT: phase_len = long_wait ? LEN_CLEAR : LEN_CMD;
            default:     phase_len = CNT_W'(1);
        endcase
    end

    assign phase_last = (cnt_q == phase_len - CNT_W'(1));

    always_comb begin
        state_d     = state_q;
        cnt_d       = '0;
        lcd_rs_d    = lcd_rs_q;
        lcd_data_d  = lcd_data_q;
        init_done_d = init_done_q;
`ifdef LCD_INIT_SEQ_EN
        rom_idx_d   = rom_idx_q;
`endif
        case (state_q)
            S_POWERUP: begin
                if (phase_last) begin
`ifdef LCD_INIT_SEQ_EN
                    state_d = S_INIT_LOAD;
`else
                    state_d     = S_IDLE;
                    init_done_d = 1'b1;
`endif
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
`ifdef LCD_INIT_SEQ_EN
            S_INIT_LOAD: begin
                lcd_rs_d   = 1'b0;
                lcd_data_d = init_rom(rom_idx_q);
                rom_idx_d  = rom_idx_q + 3'd1;
                state_d    = S_SETUP;
            end
`endif
            S_IDLE: begin
                // req_* are only looked at on the handshake cycle.
                if (req_valid) begin
                    lcd_rs_d   = req_rs;
                    lcd_data_d = req_data;
                    state_d    = S_SETUP;
                end
            end
            S_SETUP: begin
                if (phase_last) state_d = S_PULSE;
                else            cnt_d   = cnt_q + CNT_W'(1);
            end
            S_PULSE: begin
                if (phase_last) state_d = S_HOLD;
                else            cnt_d   = cnt_q + CNT_W'(1);
            end
            S_HOLD: begin
                if (phase_last) state_d = S_EXEC_WAIT;
                else            cnt_d   = cnt_q + CNT_W'(1);
            end
            S_EXEC_WAIT: begin
                if (phase_last) begin
`ifdef LCD_INIT_SEQ_EN
                    if (init_done_q) begin
                        state_d = S_IDLE;
                    end else if (rom_idx_q == ROM_LEN) begin
                        state_d     = S_IDLE;
                        init_done_d = 1'b1;
                    end else begin
                        state_d = S_INIT_LOAD;
                    end
`else
                    state_d = S_IDLE;
`endif
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = S_POWERUP;
        endcase
    end

    // E is registered from the next state so it is high exactly while in PULSE.
    assign lcd_e_d = (state_d == S_PULSE);

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its _d value from before the edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_POWERUP;
            cnt_q       <= '0;
            lcd_e_q     <= 1'b0;
            lcd_rs_q    <= 1'b0;
            lcd_data_q  <= 8'h00;
            init_done_q <= 1'b0;
`ifdef LCD_INIT_SEQ_EN
            rom_idx_q   <= 3'd0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            lcd_e_q     <= lcd_e_d;
            lcd_rs_q    <= lcd_rs_d;
            lcd_data_q  <= lcd_data_d;
            init_done_q <= init_done_d;
`ifdef LCD_INIT_SEQ_EN
            rom_idx_q   <= rom_idx_d;
`endif
        end
    end

    assign req_ready = (state_q == S_IDLE);
    assign busy      = !req_ready;
    assign init_done = init_done_q;
    assign LCD_E     = lcd_e_q;
    assign LCD_RS    = lcd_rs_q;
    assign LCD_RW    = 1'b0;
    assign LCD_data  = lcd_data_q;

endmodule

// File: tb/tb_lcd_sequencer.sv
// Testbench for lcd_sequencer: randomized byte traffic checked by a
// scoreboard. The driver pushes each issued transfer into a queue; the
// monitor pops one per LCD_E pulse and checks pin values and pulse / ready
// timing derived from the phase lengths.

module tb_lcd_sequencer;

    localparam int T_POWERUP    = 10;
    localparam int T_SETUP      = 2;
    localparam int T_PULSE      = 4;
    localparam int T_HOLD       = 1;
    localparam int T_CMD_WAIT   = 8;
    localparam int T_CLEAR_WAIT = 20;
    localparam int WAIT_LIMIT   = 1000;

    typedef struct packed {
        bit         init;
        bit         rs;
        logic [7:0] data;
    } xfer_t;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       req_valid;
    logic       req_ready;
    logic       req_rs;
    logic [7:0] req_data;
    logic       busy;
    logic       init_done;
    logic       LCD_E;
    logic       LCD_RS;
    logic       LCD_RW;
    logic [7:0] LCD_data;

    int    tests = 0;
    int    fails = 0;
    xfer_t sb[$];

    lcd_sequencer #(
        .CNT_W        (20),
        .T_POWERUP    (T_POWERUP),
        .T_SETUP      (T_SETUP),
        .T_PULSE      (T_PULSE),
        .T_HOLD       (T_HOLD),
        .T_CMD_WAIT   (T_CMD_WAIT),
        .T_CLEAR_WAIT (T_CLEAR_WAIT)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_rs    (req_rs),
        .req_data  (req_data),
        .busy      (busy),
        .init_done (init_done),
        .LCD_E     (LCD_E),
        .LCD_RS    (LCD_RS),
        .LCD_RW    (LCD_RW),
        .LCD_data  (LCD_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Execution wait of a transfer, straight from the panel's command rules.
    function automatic int wait_of(input xfer_t x);
        return (!x.rs && x.data < 8'd4) ? T_CLEAR_WAIT : T_CMD_WAIT;
    endfunction

    // ---------------------------------------------------------------- monitor
    int    cyc = 0;
    bit    e_prev, rdy_prev, rst_prev, have_cur, chk_latch;
    int    exp_rise = -1, exp_fall = -1, exp_ready = -1;
    int    free_cyc;
    xfer_t cur;

    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (!reset_n) begin
                e_prev = 0; rdy_prev = 0; rst_prev = 0; have_cur = 0; chk_latch = 0;
                exp_rise = -1; exp_fall = -1; exp_ready = -1;
            end else begin
                if (!rst_prev) begin
                    rst_prev = 1;
`ifdef LCD_INIT_SEQ_EN
                    exp_rise = cyc + T_POWERUP + 1 + T_SETUP;
`else
                    exp_ready = cyc + T_POWERUP;
`endif
                end
                if (chk_latch) begin
                    chk_latch = 0;
                    if (sb.size() > 0) begin
                        check("latch_rs", LCD_RS, sb[0].rs);
                        check("latch_data", LCD_data, sb[0].data);
                    end
                end
                if (req_ready && !rdy_prev) begin
                    check("ready_rise_cycle", cyc, exp_ready);
                    check("init_done_with_ready", init_done, 1);
                    if (have_cur) check("data_retained", {LCD_RS, LCD_data}, {cur.rs, cur.data});
                    exp_ready = -1;
                end
                if (req_valid && req_ready) begin
                    exp_rise  = cyc + T_SETUP + 1;
                    chk_latch = 1;
                end
                if (LCD_E && !e_prev) begin
                    check("e_rise_cycle", cyc, exp_rise);
                    exp_rise = -1;
                    check("busy_during_xfer", {busy, req_ready}, 2'b10);
                    check("pulse_expected", sb.size() > 0, 1);
                    if (sb.size() > 0) begin
                        cur      = sb.pop_front();
                        have_cur = 1;
                        check("rs", LCD_RS, cur.rs);
                        check("data", LCD_data, cur.data);
                        check("rw", LCD_RW, 0);
                        check("init_done_in_xfer", init_done, !cur.init);
                        exp_fall = cyc + T_PULSE;
                        free_cyc = cyc + T_PULSE + T_HOLD + wait_of(cur);
                        if (cur.init && sb.size() > 0 && sb[0].init)
                            exp_rise = free_cyc + 1 + T_SETUP;
                        else
                            exp_ready = free_cyc;
                    end
                end
                if (!LCD_E && e_prev) check("e_fall_cycle", cyc, exp_fall);
                if (LCD_E && have_cur)
                    check("pulse_bus_stable", {LCD_RS, LCD_data}, {cur.rs, cur.data});
                e_prev   = LCD_E;
                rdy_prev = req_ready;
            end
        end
    end

    // ----------------------------------------------------------------- driver
    task automatic do_reset();
        reset_n = 1'b0;
        sb.delete();
        #1;
        check("rst_e", LCD_E, 0);
        check("rst_rs", LCD_RS, 0);
        check("rst_rw", LCD_RW, 0);
        check("rst_data", LCD_data, 0);
        check("rst_ready", req_ready, 0);
        check("rst_busy", busy, 1);
        check("rst_init_done", init_done, 0);
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
`ifdef LCD_INIT_SEQ_EN
        sb.push_back('{init: 1'b1, rs: 1'b0, data: 8'h38});
        sb.push_back('{init: 1'b1, rs: 1'b0, data: 8'h38});
        sb.push_back('{init: 1'b1, rs: 1'b0, data: 8'h0C});
        sb.push_back('{init: 1'b1, rs: 1'b0, data: 8'h01});
        sb.push_back('{init: 1'b1, rs: 1'b0, data: 8'h06});
`endif
        // Requests while not ready must be ignored.
        req_valid = 1'b1;
        repeat (4) begin
            req_rs   = 1'($urandom);
            req_data = 8'($urandom);
            @(posedge clk);
            #1;
        end
        req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!req_ready && n < WAIT_LIMIT);
        check("idle_within_bound", n < WAIT_LIMIT, 1);
        @(posedge clk);
        #1;
    endtask

    // Issue one byte; returns just after its handshake edge. With hold set,
    // req_valid stays high so the caller's next send follows back-to-back.
    task automatic send(input bit rs, input logic [7:0] d, input bit hold);
        int n = 0;
        sb.push_back('{init: 1'b0, rs: rs, data: d});
        req_valid = 1'b1;
        req_rs    = rs;
        req_data  = d;
        do begin
            @(negedge clk);
            n++;
        end while (!req_ready && n < WAIT_LIMIT);
        check("handshake_within_bound", n < WAIT_LIMIT, 1);
        @(posedge clk);
        #1;
        if (!hold) begin
            req_valid = 1'b0;
            req_rs    = 1'($urandom);
            req_data  = 8'($urandom);
        end
    endtask

    initial begin
        req_valid = 1'b0;
        req_rs    = 1'b0;
        req_data  = 8'h00;
        #3;
        do_reset();
        wait_idle();

        send(1'b1, 8'h41, 1'b0); wait_idle();
        send(1'b0, 8'h01, 1'b0); wait_idle();
        send(1'b0, 8'h80, 1'b0); wait_idle();
        send(1'b0, 8'h03, 1'b0); wait_idle();
        send(1'b1, 8'h55, 1'b1);
        send(1'b0, 8'h02, 1'b0); wait_idle();

        for (int i = 0; i < 40; i++) begin
            bit         rs   = 1'($urandom);
            logic [7:0] d    = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom);
            bit         hold = 1'($urandom);
            send(rs, d, hold);
            if (!hold) begin
                repeat ($urandom_range(0, 3)) begin
                    @(posedge clk);
                    #1;
                end
            end
        end
        wait_idle();

        // Reset in the middle of an E pulse.
        begin
            int n = 0;
            send(1'b1, 8'h5A, 1'b0);
            do begin
                @(negedge clk);
                n++;
            end while (!LCD_E && n < WAIT_LIMIT);
            check("e_seen_before_reset", LCD_E, 1);
            #2;
            do_reset();
        end
        wait_idle();
        send(1'b0, 8'h0C, 1'b0);
        wait_idle();

        check("scoreboard_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", tests, fails);
        $fatal(1, "watchdog expired");
    end

endmodule
